// File: rtl/reg_file_2r_3w_sync.sv
// 2-read / 3-write register file: registered reads with a valid strobe, write-first
// bypass, fixed write priority (wr2 > wr1 > wr0), collision pulse and sticky range error.
module reg_file_2r_3w_sync #(
   parameter int WIDTH  = 64,
   parameter int DEPTH  = 40,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd0_en,
   input  logic [ADDR_W-1:0] rd0_addr,
   output logic [WIDTH-1:0]  rd0_data,
   output logic              rd0_valid,
   input  logic              rd1_en,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic [WIDTH-1:0]  rd1_data,
   output logic              rd1_valid,
   input  logic              wr0_en,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [WIDTH-1:0]  wr0_data,
   input  logic              wr1_en,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [WIDTH-1:0]  wr1_data,
   input  logic              wr2_en,
   input  logic [ADDR_W-1:0] wr2_addr,
   input  logic [WIDTH-1:0]  wr2_data,
   output logic              wr_collision,
   output logic              addr_err
);

   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_EXT);
   endfunction

   // Port bundles, indexed by port number so priority follows loop order.
   logic [2:0]        wr_en_v;
   logic [2:0]        wr_ok;
   logic [ADDR_W-1:0] wr_addr [3];
   logic [WIDTH-1:0]  wr_data [3];
   logic [1:0]        rd_en_v;
   logic [1:0]        rd_ok;
   logic [ADDR_W-1:0] rd_addr [2];
   logic [WIDTH-1:0]  rd_next [2];

   assign wr_en_v    = {wr2_en, wr1_en, wr0_en};
   assign wr_addr[0] = wr0_addr;
   assign wr_addr[1] = wr1_addr;
   assign wr_addr[2] = wr2_addr;
   assign wr_data[0] = wr0_data;
   assign wr_data[1] = wr1_data;
   assign wr_data[2] = wr2_data;
   assign rd_en_v    = {rd1_en, rd0_en};
   assign rd_addr[0] = rd0_addr;
   assign rd_addr[1] = rd1_addr;

   always_comb begin
      for (int w = 0; w < 3; w++) begin
         wr_ok[w] = wr_en_v[w] && in_range(wr_addr[w]);
      end
      for (int p = 0; p < 2; p++) begin
         rd_ok[p] = in_range(rd_addr[p]);
      end
   end

   logic [WIDTH-1:0] mem [DEPTH];

   // Later ports override earlier ones, giving wr2 > wr1 > wr0 without X on collisions.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst) begin
            mem[i] <= '0;
         end else begin
            for (int w = 0; w < 3; w++) begin
               if (wr_ok[w] && (wr_addr[w] == ADDR_W'(i))) begin
                  mem[i] <= wr_data[w];
               end
            end
         end
      end
   end

   // Read value is the stored entry, overridden by the winning same-cycle write.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_next[p] = '0;
         if (rd_ok[p]) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (rd_addr[p] == ADDR_W'(i)) begin
                  rd_next[p] = mem[i];
               end
            end
            for (int w = 0; w < 3; w++) begin
               if (wr_ok[w] && (wr_addr[w] == rd_addr[p])) begin
                  rd_next[p] = wr_data[w];
               end
            end
         end
      end
   end

   logic collide;
   logic range_err;

   always_comb begin
      collide = (wr_ok[0] && wr_ok[1] && (wr_addr[0] == wr_addr[1])) ||
                (wr_ok[0] && wr_ok[2] && (wr_addr[0] == wr_addr[2])) ||
                (wr_ok[1] && wr_ok[2] && (wr_addr[1] == wr_addr[2]));
      range_err = 1'b0;
      for (int w = 0; w < 3; w++) begin
         if (wr_en_v[w] && !wr_ok[w]) range_err = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
         if (rd_en_v[p] && !rd_ok[p]) range_err = 1'b1;
      end
   end

   // Read strobe: rdN_en in cycle N gives rdN_valid and rdN_data in N+1; data holds when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd0_data     <= '0;
         rd1_data     <= '0;
         rd0_valid    <= 1'b0;
         rd1_valid    <= 1'b0;
         wr_collision <= 1'b0;
         addr_err     <= 1'b0;
      end else begin
         rd0_valid    <= rd0_en;
         rd1_valid    <= rd1_en;
         wr_collision <= collide;
         if (rd0_en) rd0_data <= rd_next[0];
         if (rd1_en) rd1_data <= rd_next[1];
         if (range_err) addr_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_file_2r_3w_sync.sv
// Randomized bench for reg_file_2r_3w_sync against an array-based reference model
// that applies writes in port order and reads the post-write contents.
module tb_reg_file_2r_3w_sync;

   localparam int W     = 64;
   localparam int DEPTH = 40;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rd0_en = 1'b0, rd1_en = 1'b0;
   logic [AW-1:0] rd0_addr = '0, rd1_addr = '0;
   logic [W-1:0]  rd0_data, rd1_data;
   logic          rd0_valid, rd1_valid;
   logic          wr0_en = 1'b0, wr1_en = 1'b0, wr2_en = 1'b0;
   logic [AW-1:0] wr0_addr = '0, wr1_addr = '0, wr2_addr = '0;
   logic [W-1:0]  wr0_data = '0, wr1_data = '0, wr2_data = '0;
   logic          wr_collision, addr_err;

   reg_file_2r_3w_sync #(.WIDTH(W), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_valid(rd0_valid),
      .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_data(wr2_data),
      .wr_collision(wr_collision), .addr_err(addr_err)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // Scoreboard state
   int           tests = 0;
   int           failed = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] model_mem [DEPTH];
   logic [W-1:0] e_d0 = '0, e_d1 = '0;
   logic         e_v0 = 1'b0, e_v1 = 1'b0, e_col = 1'b0, e_err = 1'b0;

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Driver helpers
   task automatic idle();
      rst = 1'b0;
      rd0_en = 1'b0; rd1_en = 1'b0;
      wr0_en = 1'b0; wr1_en = 1'b0; wr2_en = 1'b0;
   endtask

   task automatic drive_wr(input int port, input logic [AW-1:0] a, input logic [W-1:0] d);
      case (port)
         0: begin wr0_en = 1'b1; wr0_addr = a; wr0_data = d; end
         1: begin wr1_en = 1'b1; wr1_addr = a; wr1_data = d; end
         default: begin wr2_en = 1'b1; wr2_addr = a; wr2_data = d; end
      endcase
   endtask

   task automatic drive_rd(input int port, input logic [AW-1:0] a);
      if (port == 0) begin rd0_en = 1'b1; rd0_addr = a; end
      else begin rd1_en = 1'b1; rd1_addr = a; end
   endtask

   // Predict from the current inputs, clock once, then compare all outputs.
   task automatic step();
      logic [W-1:0] nm [DEPTH];
      int           cnt [64];
      logic         wen [3];
      int           wa [3];
      logic [W-1:0] wd [3];
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
         e_d0 = '0; e_d1 = '0; e_v0 = 1'b0; e_v1 = 1'b0; e_col = 1'b0; e_err = 1'b0;
      end else begin
         wen[0] = wr0_en; wa[0] = int'(wr0_addr); wd[0] = wr0_data;
         wen[1] = wr1_en; wa[1] = int'(wr1_addr); wd[1] = wr1_data;
         wen[2] = wr2_en; wa[2] = int'(wr2_addr); wd[2] = wr2_data;
         nm = model_mem;
         for (int i = 0; i < 64; i++) cnt[i] = 0;
         for (int w = 0; w < 3; w++) begin
            if (wen[w]) begin
               if (wa[w] < DEPTH) begin
                  nm[wa[w]] = wd[w];
                  cnt[wa[w]]++;
               end else begin
                  e_err = 1'b1;
               end
            end
         end
         e_col = 1'b0;
         for (int i = 0; i < 64; i++) if (cnt[i] >= 2) e_col = 1'b1;
         e_v0 = rd0_en;
         e_v1 = rd1_en;
         if (rd0_en) begin
            if (int'(rd0_addr) < DEPTH) e_d0 = nm[rd0_addr];
            else begin e_d0 = '0; e_err = 1'b1; end
         end
         if (rd1_en) begin
            if (int'(rd1_addr) < DEPTH) e_d1 = nm[rd1_addr];
            else begin e_d1 = '0; e_err = 1'b1; end
         end
         model_mem = nm;
      end
      exp_q.push_back(e_d0);
      exp_q.push_back(e_d1);
      @(posedge clk);
      #1;
      check_val("rd0_data", rd0_data, exp_q.pop_front());
      check_val("rd1_data", rd1_data, exp_q.pop_front());
      check_val("rd0_valid", W'(rd0_valid), W'(e_v0));
      check_val("rd1_valid", W'(rd1_valid), W'(e_v1));
      check_val("wr_collision", W'(wr_collision), W'(e_col));
      check_val("addr_err", W'(addr_err), W'(e_err));
   endtask

   function automatic logic [AW-1:0] rand_addr();
      int r;
      r = $urandom_range(0, 15);
      if (r == 0) return AW'($urandom_range(DEPTH, 63));
      if (r < 8) return AW'($urandom_range(0, 5));
      return AW'($urandom_range(0, DEPTH - 1));
   endfunction

   // Main sequence
   initial begin
      // Reset
      rst = 1'b1;
      step();
      step();
      check_val("reset_rd0_valid", W'(rd0_valid), '0);
      check_val("reset_addr_err", W'(addr_err), '0);

      // Boundary reads after reset
      idle(); drive_rd(0, 0); drive_rd(1, 39); step();
      check_val("rst_read_v0", W'(rd0_valid), W'(1));
      check_val("rst_read_d1_39", rd1_data, '0);

      // Write through storage
      idle(); drive_wr(0, 7, 64'hA5A5); step();
      idle(); drive_rd(1, 7); step();
      check_val("wr0_then_rd1", rd1_data, 64'hA5A5);

      // Same-cycle bypass
      idle(); drive_wr(1, 12, 64'h1111); drive_rd(0, 12); step();
      check_val("bypass_rd0", rd0_data, 64'h1111);

      // Three-way collision, then two-way
      idle(); drive_wr(0, 3, 64'hAAAA); drive_wr(1, 3, 64'hBBBB); drive_wr(2, 3, 64'hCCCC); step();
      check_val("col3_pulse", W'(wr_collision), W'(1));
      idle(); drive_rd(0, 3); step();
      check_val("col3_pulse_drop", W'(wr_collision), '0);
      check_val("col3_winner", rd0_data, 64'hCCCC);
      idle(); drive_wr(0, 3, 64'hAAAA); drive_wr(1, 3, 64'hBBBB); step();
      idle(); drive_rd(1, 3); step();
      check_val("col2_winner", rd1_data, 64'hBBBB);

      // Out-of-range write and read, cleared by reset
      idle(); drive_wr(0, 45, 64'hDEAD); step();
      check_val("oor_wr_err", W'(addr_err), W'(1));
      idle(); drive_rd(0, 45); step();
      check_val("oor_rd_data", rd0_data, '0);
      check_val("oor_rd_valid", W'(rd0_valid), W'(1));
      idle(); step();
      check_val("err_sticky", W'(addr_err), W'(1));
      idle(); rst = 1'b1; step();
      check_val("err_cleared", W'(addr_err), '0);

      // Requests during reset are dropped
      idle(); drive_wr(0, 7, 64'h77); step();
      idle(); drive_rd(0, 7); step();
      idle(); rst = 1'b1; drive_rd(0, 5); drive_wr(0, 5, 64'h5555); step();
      check_val("rst_drop_valid", W'(rd0_valid), '0);
      check_val("rst_drop_data", rd0_data, '0);
      idle(); drive_rd(0, 5); step();
      check_val("rst_write_ignored", rd0_data, '0);

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         idle();
         rst = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 1) == 1) drive_wr(0, rand_addr(), {$urandom, $urandom});
         if ($urandom_range(0, 1) == 1) drive_wr(1, rand_addr(), {$urandom, $urandom});
         if ($urandom_range(0, 1) == 1) drive_wr(2, rand_addr(), {$urandom, $urandom});
         if ($urandom_range(0, 2) != 0) drive_rd(0, rand_addr());
         if ($urandom_range(0, 2) != 0) drive_rd(1, rand_addr());
         step();
      end

      idle();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
